// File: rtl/lfsr_checker.sv
// ============================================================================
// Module   : lfsr_checker
// Brief    : Self-synchronising checker for the 4-bit LFSR (x^4 + x^3 + 1)
//            serial stream. Locks, counts bit errors, drops lock on a burst.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_checker #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             preset_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       c_LOCK_LAST   = 4'(LOCK_COUNT - 1);
    localparam logic [2:0]       c_UNLOCK_LAST = 3'(UNLOCK_COUNT - 1);
    localparam logic [2:0]       c_FILL_DONE   = 3'd4;
    localparam logic [ERR_W-1:0] c_ERR_ONE     = ERR_W'(1);

    typedef enum logic [0:0] {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_h;
    logic [2:0]       r_fill;
    logic [3:0]       r_match;
    logic [2:0]       r_miss;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic w_pred;
    logic w_mismatch;
    logic w_err;

    assign w_pred     = r_h[0] ^ r_h[3];
    assign w_mismatch = bit_in ^ w_pred;
    assign w_err      = bit_valid && (r_state == S_LOCKED) && w_mismatch;

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= S_SEARCH;
            r_h         <= 4'b1111;
            r_fill      <= 3'd0;
            r_match     <= 4'd0;
            r_miss      <= 3'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            // A clear wins over a same-cycle increment; the strobe still fires.
            if (clear_cnt) begin
                r_err_count <= '0;
            end else if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + c_ERR_ONE;
            end

            if (bit_valid) begin
                if (r_state == S_SEARCH) begin
                    r_h <= {r_h[2:0], bit_in};
                    if (r_fill != c_FILL_DONE) begin
                        r_fill <= r_fill + 3'd1;
                    end else if (!w_mismatch && (r_h != 4'd0)) begin
                        if (r_match == c_LOCK_LAST) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                            r_match  <= 4'd0;
                            r_miss   <= 3'd0;
                        end else begin
                            r_match <= r_match + 4'd1;
                        end
                    end else begin
                        r_match <= 4'd0;
                    end
                end else begin
                    // Free-running reference: the received bit never feeds back here.
                    r_h <= {r_h[2:0], w_pred};
                    if (w_mismatch) begin
                        if (r_miss == c_UNLOCK_LAST) begin
                            r_state  <= S_SEARCH;
                            r_locked <= 1'b0;
                            r_fill   <= 3'd0;
                            r_match  <= 4'd0;
                            r_miss   <= 3'd0;
                        end else begin
                            r_miss <= r_miss + 3'd1;
                        end
                    end else begin
                        r_miss <= 3'd0;
                    end
                end
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

- Serial receive-side companion to the team's 4-bit LFSR pattern generator.
- Consumes one bit per valid cycle, normally the generator's q[3] stream. Polynomial: x(n+1) = x(n) XOR x(n-3), period 15.
- Self-synchronises to the incoming stream and declares lock. After lock it compares every received bit against a free-running local reference, counts bit errors, and drops lock on a burst of consecutive errors.
- Used as the built-in self-test sink for serial links driven by the LFSR.

## Interface

Parameters:
- LOCK_COUNT, 8: consecutive correct predictions in SEARCH required to lock (range 1-15).
- UNLOCK_COUNT, 3: consecutive mismatches in LOCKED that force loss of lock (range 1-7).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- preset_n  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- bit_valid  in  1  qualifies bit_in; nothing advances while low.
- bit_in  in  1  received serial bit.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe per counted error.
- err_count  out  ERR_W  saturating count of errors detected in LOCKED.

## Operation

- History register h[3:0]: h[0] is the newest bit, h[3] the bit four back. Prediction p = h[0] XOR h[3].
- Accepted bit: a cycle with bit_valid=1.
- Reset values (asserted asynchronously): h=4'b1111, state SEARCH, fill=0, match=0, miss=0, locked=0, err_pulse=0, err_count=0.
- SEARCH:
  - Each accepted bit shifts in: h <= {h[2:0], bit_in}.
  - The first 4 accepted bits after entering SEARCH only fill h; fill counts 0..4 and saturates.
  - Once fill=4, compare bit_in with p:
    - Match with h != 0: match+1.
    - Mismatch, or h == 0: match <= 0.
  - match reaching LOCK_COUNT moves the block to LOCKED and clears miss. The all-zero lockup stream therefore never locks.
- LOCKED:
  - h runs as a free local LFSR: h <= {h[2:0], p}, regardless of bit_in.
  - bit_in != p: err_pulse=1, err_count+1 (saturates at 2^ERR_W-1), miss+1.
  - bit_in == p: miss <= 0.
  - miss reaching UNLOCK_COUNT moves the block to SEARCH with fill=0 and match=0. The bit that triggered the unlock is counted as an error.
  - Because h follows p, an isolated flipped bit yields exactly one error.
- No errors are counted in SEARCH.
- clear_cnt has priority over an increment in the same cycle: err_count becomes 0, but err_pulse still fires for that error.
- bit_valid low: h, fill, match, miss and state all hold, and err_pulse=0.

## Timing

- All outputs are registered.
- err_pulse is high in the cycle after the edge that samples the erroneous bit, and lasts exactly one cycle.
- err_count updates on the same edge as err_pulse.
- locked rises on the edge that samples the LOCK_COUNT-th counted match. It is observed high in the following cycle.
- locked falls on the edge that samples the UNLOCK_COUNT-th consecutive mismatch.
- There is no throughput limit: back-to-back valid bits are accepted every cycle.
- preset_n deassertion is synchronised externally. The first edge after release may accept a bit.

## Test plan

- **Lock from reset:**
  - Stimulus: release preset_n, then drive bit_valid=1 continuously with the generator stream from its preset state: 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0 repeating.
  - Required: locked=0 through the 12th bit, locked=1 after the 12th edge (4 fill bits + 8 matches), err_count=0 throughout.
- **Single-bit error:**
  - Stimulus: after lock, invert one bit.
  - Required: err_pulse high for 1 cycle, err_count=1, locked stays 1, no further errors over 30 clean bits.
- **Burst unlock:**
  - Stimulus: after lock, invert 3 consecutive bits.
  - Required: err_count=3, locked=0 after the 3rd bit; clean stream resumes and locked returns after 12 more valid bits.
- **Lockup stream:**
  - Stimulus: drive 100 zeros with valid=1.
  - Required: locked never asserts, err_count=0.
- **Gaps and clear:**
  - Stimulus: locked stream with bit_valid toggling every other cycle.
  - Required: no errors.
  - Stimulus: assert clear_cnt on the same cycle as an injected error.
  - Required: err_count=0, err_pulse=1.
- **Saturation and reset mid-run:**
  - Stimulus: ERR_W=2, with isolated errors spaced so lock holds; inject 5 errors.
  - Required: err_count sticks at 3.
  - Stimulus: pulse preset_n low mid-stream.
  - Required: all outputs return to 0 immediately, and relock takes 12 valid bits.
